// File: rtl/dmux_pkg.sv
// Shared definitions for the 1-to-N demultiplexer scheduler slice.
package dmux_pkg;

  localparam int DMUX_WIDTH_DEF = 8;
  localparam int DMUX_NOUT_DEF  = 4;
  localparam int BURST_W        = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/dmux_onehot.sv
// N-way combinational demux of a single valid bit, steered by a channel index.
module dmux_onehot #(
  parameter  int N_OUT = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic             vld,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] valid
);

  always_comb begin
    valid      = '0;
    valid[sel] = vld;
  end

endmodule

// File: rtl/dmux_scheduler.sv
// Steers bursts of a valid/ready word stream to one of N_OUT channels through a one-entry buffer.
module dmux_scheduler
  import dmux_pkg::*;
#(
  parameter  int WIDTH = DMUX_WIDTH_DEF,
  parameter  int N_OUT = DMUX_NOUT_DEF,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  input  logic               cfg_rr,
  input  logic [SEL_W-1:0]   cfg_dest,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               busy
);

  buf_state_e         state_p1, state_d;
  logic [WIDTH-1:0]   data_p1;
  logic [SEL_W-1:0]   sel_p1;
  logic               vld_p1;

  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   pkt_sel;
  logic [BURST_W-1:0] beat;
  logic [BURST_W-1:0] burst_len;
  logic               burst_rr;

  logic               first;
  logic [SEL_W-1:0]   dest;
  logic [BURST_W-1:0] burst_cfg;
  logic               mode_rr;
  logic               last;
  logic               fire;
  logic               accept;

  // Burst bookkeeping: configuration is taken live on the first beat, latched copies afterwards.
  always_comb begin
    first     = (beat == '0);
    dest      = first ? (cfg_rr ? rr_ptr : cfg_dest) : pkt_sel;
    burst_cfg = first ? cfg_burst : burst_len;
    mode_rr   = first ? cfg_rr : burst_rr;
    last      = (beat == burst_cfg);
  end

  assign vld_p1   = (state_p1 == FULL);
  assign fire     = |(out_valid & out_ready);
  assign in_ready = (state_p1 == EMPTY) || fire;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_p1;
    case (state_p1)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (fire && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_p1 <= EMPTY;
    else     state_p1 <= state_d;
  end

  // Stage p0 -> p1: word and its channel are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      sel_p1  <= '0;
    end else if (accept) begin
      data_p1 <= in_data;
      sel_p1  <= dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat      <= '0;
      rr_ptr    <= '0;
      pkt_sel   <= '0;
      burst_len <= '0;
      burst_rr  <= 1'b0;
    end else if (accept) begin
      beat <= last ? '0 : beat + BURST_W'(1);
      if (first) begin
        pkt_sel   <= dest;
        burst_len <= cfg_burst;
        burst_rr  <= cfg_rr;
      end
      if (last && mode_rr) rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

  dmux_onehot #(
    .N_OUT (N_OUT)
  ) u_onehot (
    .vld   (vld_p1),
    .sel   (sel_p1),
    .valid (out_valid)
  );

  assign out_data = data_p1;
  assign cur_sel  = sel_p1;
  assign busy     = (beat != '0) || vld_p1;

endmodule

// File: tb/tb_dmux_scheduler.sv
// Directed bench for dmux_scheduler: fixed, round-robin, back-pressure, config, reset and streaming cases.
module tb_dmux_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       cfg_rr;
  logic [1:0] cfg_dest;
  logic [7:0] cfg_burst;
  logic [1:0] cur_sel;
  logic       busy;

  int checks = 0;
  int errors = 0;

  dmux_scheduler #(.WIDTH(8), .N_OUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_rr    (cfg_rr),
    .cfg_dest  (cfg_dest),
    .cfg_burst (cfg_burst),
    .cur_sel   (cur_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'hEE; out_ready = 4'hF;
    cfg_rr = 1'b0; cfg_dest = 2'd0; cfg_burst = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b exp %b", out_valid, 4'b0000); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, 8'h00); end
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL reset_cur_sel got %0d exp %0d", cur_sel, 0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp %b", busy, 1'b0); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp %b", in_ready, 1'b1); end
  endtask

  task automatic test_fixed;
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    cfg_rr = 1'b0; cfg_dest = 2'd2; cfg_burst = 8'd0; out_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fixed_in_ready[%0d] got %b exp %b", i, in_ready, 1'b1); end
      tick();
      checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL fixed_out_valid[%0d] got %b exp %b", i, out_valid, 4'b0100); end
      checks++; if (out_data !== vals[i]) begin errors++; $display("FAIL fixed_out_data[%0d] got %h exp %h", i, out_data, vals[i]); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL fixed_drain got %b exp %b", out_valid, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fixed_busy got %b exp %b", busy, 1'b0); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_v;
    logic [1:0] exp_ch;
    cfg_rr = 1'b1; cfg_burst = 8'd1; out_ready = 4'hF;
    // ten words: two per channel, then the pointer has wrapped back to channel 0
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      tick();
      exp_ch = 2'((i / 2) % 4);
      exp_v  = 4'b0001 << exp_ch;
      checks++; if (cur_sel !== exp_ch) begin errors++; $display("FAIL rr_cur_sel[%0d] got %0d exp %0d", i, cur_sel, exp_ch); end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rr_out_valid[%0d] got %b exp %b", i, out_valid, exp_v); end
      checks++; if (out_data !== 8'(i)) begin errors++; $display("FAIL rr_out_data[%0d] got %h exp %h", i, out_data, 8'(i)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    cfg_rr = 1'b1; cfg_burst = 8'd0; out_ready = 4'hF;
    in_valid = 1'b1; in_data = 8'h40;
    #1;
    tick();
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL bp_first_sel got %0d exp %0d", cur_sel, 0); end
    in_data = 8'h41;
    #1;
    tick();
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_second_valid got %b exp %b", out_valid, 4'b0010); end
    out_ready = 4'b1101; in_data = 8'h42;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_comb got %b exp %b", in_ready, 1'b0); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b exp %b", c, out_valid, 4'b0010); end
      checks++; if (out_data !== 8'h41) begin errors++; $display("FAIL bp_hold_data[%0d] got %h exp %h", c, out_data, 8'h41); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d] got %b exp %b", c, in_ready, 1'b0); end
    end
    out_ready = 4'hF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp %b", in_ready, 1'b1); end
    tick();
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL bp_third_valid got %b exp %b", out_valid, 4'b0100); end
    checks++; if (out_data !== 8'h42) begin errors++; $display("FAIL bp_third_data got %h exp %h", out_data, 8'h42); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain got %b exp %b", out_valid, 4'b0000); end
  endtask

  task automatic test_midburst_cfg;
    logic [1:0] exp_ch;
    cfg_rr = 1'b0; cfg_dest = 2'd1; cfg_burst = 8'd3; out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h50 + 8'(i);
      #1;
      tick();
      if (i == 1) cfg_dest = 2'd3;
      exp_ch = (i < 4) ? 2'd1 : 2'd3;
      checks++; if (cur_sel !== exp_ch) begin errors++; $display("FAIL mid_cur_sel[%0d] got %0d exp %0d", i, cur_sel, exp_ch); end
      checks++; if (out_data !== 8'h50 + 8'(i)) begin errors++; $display("FAIL mid_out_data[%0d] got %h exp %h", i, out_data, 8'h50 + 8'(i)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_drain got %b exp %b", out_valid, 4'b0000); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_open_burst got %b exp %b", busy, 1'b1); end
  endtask

  task automatic test_reset_midburst;
    // burst of 4 to ch3 is one word in; this word makes beat 2 and stays buffered
    cfg_rr = 1'b1; cfg_burst = 8'd3; out_ready = 4'h0;
    in_valid = 1'b1; in_data = 8'h66;
    #1;
    tick();
    checks++; if (cur_sel !== 2'd3) begin errors++; $display("FAIL rstmid_pre_sel got %0d exp %0d", cur_sel, 3); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %b exp %b", busy, 1'b1); end
    in_valid = 1'b0; out_ready = 4'hF; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_out_valid got %b exp %b", out_valid, 4'b0000); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rstmid_out_data got %h exp %h", out_data, 8'h00); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp %b", busy, 1'b0); end
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL rstmid_cur_sel got %0d exp %0d", cur_sel, 0); end
    in_valid = 1'b1; in_data = 8'h77;
    #1;
    tick();
    checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL rstmid_new_burst_valid got %b exp %b", out_valid, 4'b0001); end
    checks++; if (out_data !== 8'h77) begin errors++; $display("FAIL rstmid_new_burst_data got %h exp %h", out_data, 8'h77); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_ch;
    logic [3:0] exp_v;
    do_reset();
    cfg_rr = 1'b1; cfg_burst = 8'd0; out_ready = 4'hF;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp %b", i, in_ready, 1'b1); end
      tick();
      exp_ch = 2'(i % 4);
      exp_v  = 4'b0001 << exp_ch;
      checks++; if (out_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL b2b_out_data[%0d] got %h exp %h", i, out_data, 8'hA0 + 8'(i)); end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_out_valid[%0d] got %b exp %b", i, out_valid, exp_v); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_no_dup got %b exp %b", out_valid, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp %b", busy, 1'b0); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'hF;
    cfg_rr = 1'b0; cfg_dest = 2'd0; cfg_burst = 8'd0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_midburst_cfg();
    test_reset_midburst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmux_scheduler.md
Name: dmux_scheduler

Overview:
- Sequencing controller for the 1-to-N demultiplexer datapath.
- Accepts a single valid/ready word stream and steers each burst of words to one of N_OUT output channels.
- Channel choice is either a fixed configured destination or round-robin across channels.
- Contains a one-entry output register (throughput 1 word/cycle) and sits between a single producer and N_OUT consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- N_OUT, 4, number of output channels; power of two, 2..8.
- SEL_W, $clog2(N_OUT), width of channel index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  WIDTH  buffered word, broadcast to all channels.
- out_valid  output  N_OUT  one-hot valid; only the bit of the selected channel may be 1.
- out_ready  input  N_OUT  per-channel consumer ready.
- cfg_rr  input  1  1 = round-robin, 0 = fixed destination.
- cfg_dest  input  SEL_W  fixed destination channel when cfg_rr=0.
- cfg_burst  input  8  burst length minus 1; range 1..256 words.
- cur_sel  output  SEL_W  channel of the buffered word.
- busy  output  1  a burst is in progress (beat counter != 0) or the buffer is full.

Behaviour:
- Reset (synchronous): buffer empty, out_valid=0, out_data=0, cur_sel=0, rr_ptr=0, beat=0, busy=0. A word held at reset is discarded; a burst interrupted by reset is abandoned.
- Buffer states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on fire without accept.
  - FULL -> FULL on fire with simultaneous accept.
- Accept = in_valid & in_ready.
- Fire = out_valid[cur_sel] & out_ready[cur_sel].
- in_ready = EMPTY | fire. This is combinational from out_ready; there is no combinational path from in_valid.
- out_valid[i] = FULL & (cur_sel == i). All other bits are 0. out_data holds its value while FULL and not fired.
- Latency: a word accepted at edge k is presented at out_* after edge k; minimum latency 1 cycle.
- Destination choice at accept:
  - If beat==0 (first word of a burst): dest = cfg_rr ? rr_ptr : cfg_dest. The block latches this dest into pkt_sel.
  - Otherwise: dest = pkt_sel.
  - The word's dest is registered into cur_sel together with the data.
- Beat counter: increments on each accept. When beat == cfg_burst on an accept, that word is the last of the burst: beat returns to 0. If cfg_rr=1, rr_ptr <= rr_ptr+1 mod N_OUT (wraps from N_OUT-1 to 0).
- cfg_rr, cfg_dest and cfg_burst are sampled only at beat==0. Changes mid-burst take effect on the next burst. The block compares beat against the cfg_burst value latched at burst start.
- Blocked channel: the block never skips or reorders. A stalled selected channel back-pressures in_ready; other channels' out_ready are ignored.
- cfg_burst=0 gives single-word bursts; round-robin then advances every word.
- cfg_dest >= N_OUT is not reachable because SEL_W bits index exactly N_OUT.
- out_ready bits of unselected channels have no effect in any state.

Decomposition:
- Shared package dmux_pkg:
  - DMUX_WIDTH_DEF=8, DMUX_NOUT_DEF=4.
  - Buffer state encoding EMPTY=1'b0, FULL=1'b1.
  - Burst-count width constant BURST_W=8.
- Sub-module dmux_onehot (N_OUT-way combinational demux of a 1-bit valid by sel), generalising the existing 2-way dmux. It produces out_valid from FULL and cur_sel.
- Everything else lives in dmux_scheduler.

Test Plan:
- Fixed mode: cfg_rr=0, cfg_dest=2, cfg_burst=0, all out_ready=1, stream 0x11,0x22,0x33 back-to-back -> out_valid=4'b0100 for three consecutive cycles starting one cycle after the first accept, data 0x11,0x22,0x33, in_ready held 1.
- Round-robin: cfg_rr=1, cfg_burst=1, all ready, 8 words 0x00..0x07 -> channels 0,0,1,1,2,2,3,3, then rr_ptr wraps to 0 for the next word.
- Back-pressure: cfg_rr=1, cfg_burst=0, out_ready[1]=0 for 5 cycles while the second word targets ch1 -> out_valid=4'b0010 stable, out_data stable, in_ready=0; the next cycle after out_ready[1]=1 fires and the third word goes to ch2.
- Mid-burst config: cfg_rr=0, cfg_dest=1, cfg_burst=3; change cfg_dest to 3 after word 2 -> words 1-4 all go to ch1; word 5 goes to ch3.
- Reset mid-burst: assert rst with the buffer full and beat=2 -> next cycle out_valid=0, out_data=0, busy=0, cur_sel=0; the first word after reset starts a new burst at rr_ptr=0.
- Simultaneous fire and accept with a FULL buffer: throughput of 1 word/cycle is sustained for 16 words with no bubble and no duplication.
